// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmitter and receiver.
//   - tx_state_t : transmitter FSM state encoding
//   - UART_IDLE  : idle (mark) level of the serial line
//   - max_u      : constant helper used to size shared tick counters
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART serial transmitter. Frames a parallel word as
//   start bit, DBIT data bits LSB first, optional parity bit, stop phase.
//   Bit timing advances only on s_tick (oversample tick from the baud
//   generator); the line idles high.
//
// Parameters
//   DBIT        data bits per frame (5..9)
//   OVERSAMPLE  s_tick pulses per bit period (>= 2)
//   SB_TICK     s_tick pulses in the stop phase
//   PARITY_ODD  0 = even, 1 = odd parity (parity build only)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   s_tick       1-clk oversample tick
//   tx_start     send request, honoured only while tx_busy = 0
//   tx_din       word to send, sampled in the accept cycle
//   tx           registered serial output
//   tx_busy      high from the cycle after accept until tx_done_tick
//   tx_done_tick 1-clk pulse in the first idle cycle after a frame
//
// Build option
//   UART_TX_PARITY_EN : when defined, a parity bit is sent after the data
//                       bits. When undefined, DATA goes straight to STOP.
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // One tick counter serves both the bit periods and the stop phase.
  localparam int unsigned SW = $clog2(max_u(OVERSAMPLE, SB_TICK));
  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SW-1:0] OS_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  localparam bit CFG_OK = (DBIT >= 5) && (DBIT <= 9) && (OVERSAMPLE >= 2) && (SB_TICK >= 1);

  if (!CFG_OK) begin : g_cfg_check
    $error("uart_tx: unsupported parameter set");
  end

  tx_state_t       state;
  logic [SW-1:0]   s_cnt;
  logic [NW-1:0]   n_cnt;
  logic [DBIT-1:0] shreg;

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the word at accept time, because the shift
  // register no longer holds the whole word by the time the bit goes out.
  logic par_bit;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tx           <= UART_IDLE;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shreg        <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;

      case (state)
        IDLE: begin
          tx <= UART_IDLE;
          if (tx_start) begin
            shreg   <= tx_din;
            s_cnt   <= '0;
            tx      <= ~UART_IDLE;
            tx_busy <= 1'b1;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            par_bit <= (^tx_din) ^ PARITY_ODD;
`endif
          end
        end

        START: begin
          if (s_tick) begin
            if (s_cnt == OS_LAST) begin
              s_cnt <= '0;
              n_cnt <= '0;
              tx    <= shreg[0];
              state <= DATA;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s_cnt == OS_LAST) begin
              s_cnt <= '0;
              shreg <= {1'b0, shreg[DBIT-1:1]};
              if (n_cnt == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                tx    <= par_bit;
                state <= PARITY;
`else
                tx    <= UART_IDLE;
                state <= STOP;
`endif
              end else begin
                // tx is registered, so the next bit is taken one position
                // ahead of the shift that happens in this same cycle.
                n_cnt <= n_cnt + NW'(1);
                tx    <= shreg[1];
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s_cnt == OS_LAST) begin
              s_cnt <= '0;
              tx    <= UART_IDLE;
              state <= STOP;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
`endif

        STOP: begin
          tx <= UART_IDLE;
          if (s_tick) begin
            if (s_cnt == SB_LAST) begin
              s_cnt        <= '0;
              tx_busy      <= 1'b0;
              tx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

        default: begin
          tx      <= UART_IDLE;
          tx_busy <= 1'b0;
          s_cnt   <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
